// File: rtl/tdp_ram_clr.sv
`default_nettype none
// ============================================================================
//  Module   : tdp_ram_clr
//  Purpose  : True dual-port synchronous RAM for line and histogram buffers.
//             Adds per-lane byte enables, selectable same-port read-during-
//             write, an optional output register with read-valid strobes,
//             same-address write collision arbitration and a clear engine
//             that zero-fills the whole array after reset or on request.
//  Ports    : clk, rst (async, active high)
//             clear      - one-cycle request to zero-fill the array
//             busy       - high while the clear sweep runs
//             collision  - pulse: both ports wrote the same address
//             data_x/addr_x/we_x/be_x/rd_x - port x request (x = a, b)
//             q_x/valid_x                  - port x read data and strobe
//  Revision : 1.0 - initial release
// ============================================================================
module tdp_ram_clr #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 6,
    parameter int LANE_WIDTH     = 8,
    parameter int OUT_REG        = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NLANES        = DATA_WIDTH / LANE_WIDTH,
    localparam int DEPTH         = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    output logic                  busy,
    output logic                  collision,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic                  we_a,
    input  logic [NLANES-1:0]     be_a,
    input  logic                  rd_a,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic                  valid_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  we_b,
    input  logic [NLANES-1:0]     be_b,
    input  logic                  rd_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  valid_b
);

    localparam logic [0:0]            c_IDLE      = 1'b0;
    localparam logic [0:0]            c_CLEAR     = 1'b1;
    localparam logic [0:0]            c_RST_STATE = (CLEAR_ON_RESET != 0) ? c_CLEAR : c_IDLE;
    localparam logic [ADDR_WIDTH-1:0] c_LAST      = '1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_acc_a, w_acc_b;
    logic [NLANES-1:0]     w_wen_a, w_wen_b;
    logic [DATA_WIDTH-1:0] w_old_a, w_old_b;
    logic [DATA_WIDTH-1:0] w_mrg_a, w_mrg_b;
    logic [DATA_WIDTH-1:0] w_rd_a, w_rd_b;

    logic [DATA_WIDTH-1:0] r_q1_a, r_q1_b;
    logic                  r_v1_a, r_v1_b;
    logic                  r_coll;

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_RST_STATE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter parks at the last address once the sweep ends; it is
    // reloaded only when a new sweep starts.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (clear) begin
                    w_state_nxt = c_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            c_CLEAR: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    assign busy = (r_state == c_CLEAR);

    // ------------------------------------------------------------------
    // Access qualification
    // ------------------------------------------------------------------
    assign w_acc_a = !busy && (we_a || rd_a);
    assign w_acc_b = !busy && (we_b || rd_b);
    assign w_wen_a = {NLANES{we_a && !busy}} & be_a;
    assign w_wen_b = {NLANES{we_b && !busy}} & be_b;

    // ------------------------------------------------------------------
    // Array. Port B lanes are written first so that port A wins any lane
    // both ports enable on a shared address.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (busy) begin
            r_mem[r_cnt] <= '0;
        end else begin
            for (int i = 0; i < NLANES; i++) begin
                if (w_wen_b[i]) begin
                    r_mem[addr_b][i*LANE_WIDTH +: LANE_WIDTH] <= data_b[i*LANE_WIDTH +: LANE_WIDTH];
                end
                if (w_wen_a[i]) begin
                    r_mem[addr_a][i*LANE_WIDTH +: LANE_WIDTH] <= data_a[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read word selection. The merged view only ever uses the port's own
    // write data, so a read of an address the other port is writing
    // returns the old word.
    // ------------------------------------------------------------------
    assign w_old_a = r_mem[addr_a];
    assign w_old_b = r_mem[addr_b];

    generate
        for (genvar g = 0; g < NLANES; g++) begin : g_lane
            assign w_mrg_a[g*LANE_WIDTH +: LANE_WIDTH] = w_wen_a[g] ? data_a[g*LANE_WIDTH +: LANE_WIDTH]
                                                                    : w_old_a[g*LANE_WIDTH +: LANE_WIDTH];
            assign w_mrg_b[g*LANE_WIDTH +: LANE_WIDTH] = w_wen_b[g] ? data_b[g*LANE_WIDTH +: LANE_WIDTH]
                                                                    : w_old_b[g*LANE_WIDTH +: LANE_WIDTH];
        end
    endgenerate

    assign w_rd_a = (RDW_MODE == 0) ? w_mrg_a : w_old_a;
    assign w_rd_b = (RDW_MODE == 0) ? w_mrg_b : w_old_b;

    // ------------------------------------------------------------------
    // First output stage and collision flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q1_a <= '0;
            r_q1_b <= '0;
            r_v1_a <= 1'b0;
            r_v1_b <= 1'b0;
            r_coll <= 1'b0;
        end else begin
            r_v1_a <= w_acc_a;
            r_v1_b <= w_acc_b;
            if (w_acc_a) r_q1_a <= w_rd_a;
            if (w_acc_b) r_q1_b <= w_rd_b;
            r_coll <= we_a && we_b && !busy && (addr_a == addr_b);
        end
    end

    assign collision = r_coll;

    // ------------------------------------------------------------------
    // Optional second output stage
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_q2_a, r_q2_b;
            logic                  r_v2_a, r_v2_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q2_a <= '0;
                    r_q2_b <= '0;
                    r_v2_a <= 1'b0;
                    r_v2_b <= 1'b0;
                end else begin
                    r_v2_a <= r_v1_a;
                    r_v2_b <= r_v1_b;
                    if (r_v1_a) r_q2_a <= r_q1_a;
                    if (r_v1_b) r_q2_b <= r_q1_b;
                end
            end

            assign q_a     = r_q2_a;
            assign q_b     = r_q2_b;
            assign valid_a = r_v2_a;
            assign valid_b = r_v2_b;
        end else begin : g_no_out_reg
            assign q_a     = r_q1_a;
            assign q_b     = r_q1_b;
            assign valid_a = r_v1_a;
            assign valid_b = r_v1_b;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/tdp_ram_clr.md
Name: tdp_ram_clr

Overview:
Parametrised true dual-port synchronous RAM for the HOG line and histogram buffers. It adds the following on top of a plain two-port RAM:
- per-lane byte enables
- selectable same-port read-during-write mode
- optional output pipeline register with read-valid strobes
- same-address write collision arbitration
- a built-in clear engine that zero-fills the array after reset or on request, so histogram bins start each frame at zero

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of LANE_WIDTH.
ADDR_WIDTH, 6, address bits; DEPTH = 2**ADDR_WIDTH.
LANE_WIDTH, 8, bits per byte-enable lane; NLANES = DATA_WIDTH/LANE_WIDTH.
OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
RDW_MODE, 0, same-port read-during-write: 0 = write-first (q shows merged new word), 1 = read-first (q shows old word).
CLEAR_ON_RESET, 1, 1 = start a clear sweep when rst deasserts.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
clear  in  1  one-cycle request to zero-fill the whole array
busy  out  1  high while a clear sweep is in progress
collision  out  1  one-cycle pulse: both ports wrote the same address
data_a  in  DATA_WIDTH  port A write data
addr_a  in  ADDR_WIDTH  port A address
we_a  in  1  port A write
be_a  in  NLANES  port A lane enables (qualified by we_a)
rd_a  in  1  port A read
q_a  out  DATA_WIDTH  port A read data
valid_a  out  1  q_a updated this cycle
data_b, addr_b, we_b, be_b, rd_b, q_b, valid_b: same as port A, for port B

Behaviour:
- Reset (async): q_a = q_b = 0, valid_a = valid_b = 0, collision = 0, clear counter = 0.
  - State goes to CLEAR if CLEAR_ON_RESET = 1, else IDLE; busy follows the state.
  - Array contents are not reset directly.
- FSM states are IDLE and CLEAR.
  - IDLE -> CLEAR when clear = 1; the counter loads 0.
  - In CLEAR, writes all-zero to address cnt each cycle, then cnt+1. After writing DEPTH-1 the FSM returns to IDLE. The sweep lasts exactly DEPTH cycles with busy = 1.
  - clear asserted during CLEAR is ignored; no restart.
  - rst mid-sweep aborts the sweep. With CLEAR_ON_RESET = 1 the sweep restarts from 0.
- While busy = 1, all user we/rd on both ports are ignored: no array change, valid stays 0, q holds.
- Access accept: a port access is accepted when busy = 0 and (we or rd).
  - For each accepted access, valid pulses exactly once, 1 cycle later (OUT_REG = 0) or 2 cycles later (OUT_REG = 1).
  - q changes only in the cycle valid pulses and holds otherwise. Back-to-back accesses give back-to-back valid pulses.
- Writes: lane i is written only when we = 1 and be[i] = 1. we = 1 with be = 0 writes nothing but still returns a read (counts as an access).
- Same-port read-during-write:
  - RDW_MODE = 0: q = merged word (enabled lanes new, others old).
  - RDW_MODE = 1: q = the word before the write.
- Cross-port behaviour: a port reading an address the other port writes in the same cycle returns the old word.
- Collision: we_a = we_b = 1, addr_a == addr_b, busy = 0.
  - Lanes enabled on A take data_a.
  - Lanes enabled only on B take data_b.
  - collision pulses 1 cycle later, regardless of lane overlap.
  - Each port's q follows its own RDW_MODE view using its own data.
- Simultaneous clear and a user access in IDLE: the access in that cycle is accepted; the sweep starts next cycle.
- Address wrap: the counter reaches DEPTH-1 and stops; there is no wrap into user space.

Test Plan:
1. Reset-clear: CLEAR_ON_RESET = 1, ADDR_WIDTH = 6. Release rst → busy high for exactly 64 cycles. Afterwards, reads of addr 0, 37 and 63 all return 0 with valid one cycle later.
2. Byte-enable merge: DATA_WIDTH = 32. Write 0x11223344 to addr 5, then write 0xAABBCCDD with be = 0101 → a read of addr 5 returns 0x11BB33DD.
3. RDW modes: addr 9 holds 0x55.
   - Port A write 0x77 with RDW_MODE = 0 → q_a = 0x77.
   - RDW_MODE = 1 → q_a = 0x55.
   - The same-cycle port B read of addr 9 → q_b = 0x55 in both cases.
4. Collision: A writes 0x0000AAAA be = 0011, B writes 0xBBBBBBBB be = 1111, both to addr 3 → collision pulses once; a later read returns 0xBBBBAAAA.
5. Latency and busy gating: OUT_REG = 1, reads issued on 4 consecutive cycles → 4 valid pulses, 2 cycles after each read. Then assert clear and hold rd_a high during the sweep → no valid pulses until busy falls.
6. Reset mid-sweep: assert rst at sweep cycle 20 for 2 cycles → busy stays high, and the sweep restarts and lasts 64 full cycles after rst falls.
